alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
- Upstream command stage for the ALU top: buffers operation commands {A, B, SEL} in a small FIFO.
- Issues one command at a time to the ALU.
- Aligns the ALU's combinational flags with its registered result (C arrives one clock after operands; flags are valid in the operand cycle).
- Returns {result, flags} on a valid/ready response channel.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU's WIDTH.
- DEPTH, 4, command FIFO entries; power of 2, ≥2.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  FIFO not full.
- CMD_A  in  WIDTH  operand A.
- CMD_B  in  WIDTH  operand B.
- CMD_SEL  in  4  ALU select code.
- ALU_A  out  WIDTH  to ALU A.
- ALU_B  out  WIDTH  to ALU B.
- ALU_SEL  out  4  to ALU SEL.
- ALU_C  in  WIDTH  registered ALU result.
- ALU_ZERO  in  1  ALU zero_flag.
- ALU_OVF  in  1  ALU over_flow_flag.
- ALU_COUT  in  1  ALU carry_out.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  consumer accepts response.
- RSP_DATA  out  WIDTH  captured result.
- RSP_FLAGS  out  3  {cout, ovf, zero}.
- BUSY  out  1  high when FSM is not IDLE or FIFO is not empty.

Behaviour:
- Reset (RST=1, async): FIFO empty, pointers/count 0, FSM=IDLE, all outputs 0. CMD_READY rises the first cycle after RST deasserts.
- Reset mid-operation: in-flight and queued commands are discarded; no response is produced.
- Push: CMD_VALID & CMD_READY at a rising edge. CMD_READY = (count != DEPTH), combinational from the registered count only.
- Full FIFO refuses push even if a pop occurs on the same edge.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- FSM states: IDLE, ISSUE, CAPTURE, RESPOND.
  - IDLE: if FIFO not empty, pop head into ALU_A/ALU_B/ALU_SEL registers, go to ISSUE.
  - ISSUE: operands stable at the ALU. At this edge, latch {ALU_COUT, ALU_OVF, ALU_ZERO} into the flag register (the ALU captures C at the same edge). Go to CAPTURE.
  - CAPTURE: RSP_DATA <= ALU_C, RSP_FLAGS <= flag register, RSP_VALID <= 1. Go to RESPOND.
  - RESPOND: hold RSP_* stable while RSP_READY=0.
    - On RSP_READY=1: RSP_VALID <= 0.
    - If FIFO not empty, pop the next command into the ALU registers and go to ISSUE; else go to IDLE.
- ALU_A/ALU_B/ALU_SEL change only on a pop edge; otherwise they hold.
- Latency: command accepted at edge k into an idle, empty block → RSP_VALID high after edge k+3.
- Throughput: one result per 3 cycles with RSP_READY tied high.
- Ordering: responses are returned strictly in command order.

Optional Feature:
- Macro ALU_SEQ_STICKY_EN.
- Defined: adds ports STICKY_OVF (out, 1) and STICKY_CLR (in, 1).
  - STICKY_OVF is set on any CAPTURE whose ovf flag is 1.
  - It is cleared by STICKY_CLR=1 at a clock edge; set wins over clear on the same edge.
  - Reset value 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg:
  - FSM state encoding (2-bit IDLE/ISSUE/CAPTURE/RESPOND).
  - Flag bit indices FLG_ZERO=0, FLG_OVF=1, FLG_COUT=2.
  - SEL unit-field constants (SEL[3:2]).
- Sub-module alu_cmd_fifo, parameterised by WIDTH and DEPTH. Entry width is 2*WIDTH+4. It has push/pop/full/empty and the same async active-high reset.

Test Plan:
- Reset: RST pulsed mid-RESPOND with 2 commands queued → RSP_VALID=0 and BUSY=0 immediately; no responses after release; CMD_READY=1 one cycle later.
- Single op, bench ALU stub (registered C=A+B, combinational flags): CMD A=8'h05, B=8'h03 at edge k → RSP_VALID after edge k+3, RSP_DATA=8'h08, RSP_FLAGS=3'b000.
- Flag alignment: A=8'h7F, B=8'h01 then A=8'hFF, B=8'h01 back-to-back → responses 8'h80/{0,1,0} then 8'h00/{1,0,1}; no flag mixing between ops.
- Full/backpressure: RSP_READY=0, push 5 commands with DEPTH=4 → CMD_READY low after 4 FIFO entries plus 1 in flight. Hold 10 cycles: RSP_DATA stable. Release → 5 responses in order.
- Throughput: 8 queued commands, RSP_READY=1 → RSP_VALID pulses every 3rd cycle.
- ALU_SEQ_STICKY_EN: op producing ovf=1, then ovf=0 op → STICKY_OVF stays 1. STICKY_CLR on the same edge as a new ovf=1 capture → stays 1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: FSM states,
// response-flag bit positions and the ALU select unit field encodings.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESPOND = 2'd3
  } seq_state_t;

  localparam int FLG_ZERO = 0;
  localparam int FLG_OVF  = 1;
  localparam int FLG_COUT = 2;

  // Unit field carried in SEL[3:2]
  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_SHIFT = 2'b10;
  localparam logic [1:0] UNIT_CMP   = 2'b11;

  function automatic logic [1:0] sel_unit(input logic [3:0] sel);
    return sel[3:2];
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding packed {SEL, B, A} entries; pushes are refused when
// full and pops when empty, regardless of the other side's activity.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [2*WIDTH+3:0]   push_data,
  input  logic                 pop,
  output logic [2*WIDTH+3:0]   pop_data,
  output logic                 full,
  output logic                 empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [2*WIDTH+3:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push_ok;
  logic               pop_ok;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time and returns result plus
// operand-cycle flags in order. Optional sticky overflow: ALU_SEQ_STICKY_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [WIDTH-1:0] CMD_A,
  input  logic [WIDTH-1:0] CMD_B,
  input  logic [3:0]       CMD_SEL,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [3:0]       ALU_SEL,
  input  logic [WIDTH-1:0] ALU_C,
  input  logic             ALU_ZERO,
  input  logic             ALU_OVF,
  input  logic             ALU_COUT,
  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic [2:0]       RSP_FLAGS,
  output logic             BUSY
`ifdef ALU_SEQ_STICKY_EN
  ,
  output logic             STICKY_OVF,
  input  logic             STICKY_CLR
`endif
);

  seq_state_t         state;
  logic               ready_en;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               cmd_push;
  logic [2*WIDTH+3:0] fifo_head;
  logic [2:0]         flag_reg;

  // Held low through reset so the producer sees ready only after release
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  assign CMD_READY = ready_en && !fifo_full;
  assign cmd_push  = CMD_VALID && CMD_READY;
  assign fifo_pop  = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_RESPOND) && RSP_READY));
  assign BUSY      = (state != ST_IDLE) || !fifo_empty;

  alu_cmd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (cmd_push),
    .push_data ({CMD_SEL, CMD_B, CMD_A}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Flags are sampled while operands sit at the ALU; C lands one edge later
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_SEL   <= '0;
      flag_reg  <= '0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_FLAGS <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            {ALU_SEL, ALU_B, ALU_A} <= fifo_head;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          flag_reg[FLG_ZERO] <= ALU_ZERO;
          flag_reg[FLG_OVF]  <= ALU_OVF;
          flag_reg[FLG_COUT] <= ALU_COUT;
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          RSP_DATA  <= ALU_C;
          RSP_FLAGS <= flag_reg;
          RSP_VALID <= 1'b1;
          state     <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            if (fifo_pop) begin
              {ALU_SEL, ALU_B, ALU_A} <= fifo_head;
              state <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STICKY_EN
  // A new overflow capture takes priority over a concurrent clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                          STICKY_OVF <= 1'b0;
    else if ((state == ST_CAPTURE) && flag_reg[FLG_OVF]) STICKY_OVF <= 1'b1;
    else if (STICKY_CLR)                              STICKY_OVF <= 1'b0;
  end
`endif

endmodule
